// File: rtl/uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_sampler
//
// Serial receive stage of the UART. Recovers bytes from the asynchronous rx
// line using a 16x oversampling enable (baud_clock). The bit value is taken
// at the middle of each bit. The start/data/parity/stop state machine hands
// each finished byte to the consumer side with status flags and a read
// handshake. Everything runs on clk; baud_clock is a one-cycle enable.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   : the line is captured at sample counts 7, 8 and 9 of each bit.
//               The bit value (start validation included) is the 2-of-3
//               majority, decided at count 9.
//   undefined : single sample at count 8.
//
// Parameters
//   SYNC_STAGES  flops in the rx synchronizer chain (2..4)
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   baud_clock    16x oversampling tick, one clk wide
//   rx            asynchronous serial input, idle high
//   bit8          1 = 8 data bits, 0 = 7 data bits
//   parity_en     1 = a parity bit follows the data
//   odd_n_even    1 = odd parity, 0 = even parity
//   read_rx_byte  one-clk pulse: consumer has taken rx_data
//   rx_data       received byte (bit7 = 0 in 7-bit mode)
//   rx_ready      rx_data holds an unread byte
//   parity_err    parity mismatch on the byte in rx_data
//   framing_err   stop bit sampled low on the byte in rx_data
//   overflow      a frame completed while rx_ready was set
//   rx_idle       receiver is in IDLE
// ---------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow,
    output logic       rx_idle
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [3:0]             r_scnt;
    logic [2:0]             r_bit_idx;
    logic [7:0]             r_shift;
    logic                   r_perr;
    logic                   r_stop;
    logic                   r_done;

    logic [7:0]             r_rx_data;
    logic                   r_rx_ready;
    logic                   r_parity_err;
    logic                   r_framing_err;
    logic                   r_overflow;

    logic                   w_rx_s;
    logic                   w_bit;
    logic                   w_st;
    logic                   w_last_bit;

    // Synchronizer presets to the idle level so reset never looks like a start.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx_s = r_sync[SYNC_STAGES-1];

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [3:0] ST_CNT = 4'd9;

    logic r_s7;
    logic r_s8;

    // Early samples; the third vote is the live synchronized line at count 9.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s7 <= 1'b1;
            r_s8 <= 1'b1;
        end else if (baud_clock) begin
            if (r_scnt == 4'd7) r_s7 <= w_rx_s;
            if (r_scnt == 4'd8) r_s8 <= w_rx_s;
        end
    end

    assign w_bit = (r_s7 & r_s8) | (r_s7 & w_rx_s) | (r_s8 & w_rx_s);
`else
    localparam logic [3:0] ST_CNT = 4'd8;

    assign w_bit = w_rx_s;
`endif

    assign w_st       = baud_clock && (r_scnt == ST_CNT);
    // ">=" keeps the frame terminating even if bit8 flips mid-frame.
    assign w_last_bit = bit8 ? (r_bit_idx == 3'd7) : (r_bit_idx >= 3'd6);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_scnt    <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_perr    <= 1'b0;
            r_stop    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (baud_clock) begin
                r_scnt <= r_scnt + 4'd1;
                case (r_state)
                    S_IDLE: begin
                        r_scnt <= 4'd0;
                        if (!w_rx_s) begin
                            // The detecting tick counts as sample 0.
                            r_scnt  <= 4'd1;
                            r_state <= S_START;
                        end
                    end
                    S_START: begin
                        if (w_st) begin
                            if (!w_bit) begin
                                r_bit_idx <= 3'd0;
                                r_shift   <= 8'd0;
                                r_perr    <= 1'b0;
                                r_state   <= S_DATA;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        if (w_st) begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            if (w_last_bit) begin
                                // 7-bit frames take one extra right shift so
                                // the byte is right-justified with bit7 = 0.
                                r_shift <= bit8 ? {w_bit, r_shift[7:1]}
                                                : {1'b0, w_bit, r_shift[7:2]};
                                r_state <= parity_en ? S_PARITY : S_STOP;
                            end else begin
                                r_shift <= {w_bit, r_shift[7:1]};
                            end
                        end
                    end
                    S_PARITY: begin
                        if (w_st) begin
                            // Bit7 is 0 in 7-bit mode, so it never biases the XOR.
                            r_perr  <= (^r_shift) ^ w_bit ^ odd_n_even;
                            r_state <= S_STOP;
                        end
                    end
                    S_STOP: begin
                        if (w_st) begin
                            r_stop  <= w_bit;
                            r_done  <= 1'b1;
                            r_state <= w_bit ? S_IDLE : S_WAIT_HIGH;
                        end
                    end
                    S_WAIT_HIGH: begin
                        // Hold off until the line is released after a break.
                        if (w_rx_s) r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Consumer-side holding register and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_data     <= 8'd0;
            r_rx_ready    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end else if (r_done) begin
            if (!r_rx_ready || read_rx_byte) begin
                r_rx_data     <= r_shift;
                r_parity_err  <= parity_en & r_perr;
                r_framing_err <= ~r_stop;
                r_rx_ready    <= 1'b1;
                r_overflow    <= 1'b0;
            end else begin
                // Unread byte wins; the new frame is dropped.
                r_overflow <= 1'b1;
            end
        end else if (read_rx_byte && r_rx_ready) begin
            r_rx_ready    <= 1'b0;
            r_parity_err  <= 1'b0;
            r_framing_err <= 1'b0;
            r_overflow    <= 1'b0;
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_ready    = r_rx_ready;
    assign parity_err  = r_parity_err;
    assign framing_err = r_framing_err;
    assign overflow    = r_overflow;
    assign rx_idle     = (r_state == S_IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_sampler
//
// Scoreboard bench for uart_rx_sampler. The stimulus process serializes
// frames onto rx, timed by counting baud ticks. For each frame it pushes the
// expected delivered record into a queue; that record is computed from the
// byte, the frame format and the chosen parity/stop bits. A separate monitor
// pops and compares whenever the DUT presents a byte or raises overflow.
// It optionally performs the read handshake itself.
// ---------------------------------------------------------------------------
module tb_uart_rx_sampler;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int ST_VAL = 9;
`else
    localparam int ST_VAL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       baud_clock = 1'b0;
    logic       rx = 1'b1;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       read_rx_byte = 1'b0;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;
    logic       rx_idle;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   auto_read = 1'b1;
    logic prev_ready = 1'b0;
    logic prev_ovf = 1'b0;

    uart_rx_sampler #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .baud_clock   (baud_clock),
        .rx           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow),
        .rx_idle      (rx_idle)
    );

    initial forever #5 clk = ~clk;

    // 16x tick every 4 clk, changed on the falling edge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div + 1) % 4;
            baud_clock = (div == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (baud_clock !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input logic v);
        @(negedge clk);
        rx = v;
    endtask

    // Reference: what the consumer should see for one frame.
    function automatic exp_t model(input logic [7:0] data, input bit b8, input bit pen,
                                   input bit odd, input bit pbit, input bit stop);
        exp_t e;
        int   ones;
        logic [7:0] d;
        d    = b8 ? data : (data & 8'h7F);
        ones = $countones(d) + int'(pbit);
        e.d  = d;
        e.pe = pen && (((ones % 2) == 1) != odd);
        e.fe = !stop;
        e.ov = 1'b0;
        return e;
    endfunction

    // One frame, each bit 16 ticks; optional read pulse landing on the
    // completion cycle (one clk after the stop-bit sample tick).
    task automatic send_frame(input logic [7:0] data, input bit b8, input bit pen,
                              input bit odd, input bit pbit, input bit stop,
                              input bit coincide);
        int nb;
        nb = b8 ? 8 : 7;
        @(negedge clk);
        bit8       = b8;
        parity_en  = pen;
        odd_n_even = odd;
        wait_ticks(1);
        drive_bit(1'b0);
        for (int i = 0; i < nb; i++) begin
            wait_ticks(16);
            drive_bit(data[i]);
        end
        if (pen) begin
            wait_ticks(16);
            drive_bit(pbit);
        end
        wait_ticks(16);
        drive_bit(stop);
        if (coincide) begin
            wait_ticks(1 + ST_VAL);
            @(negedge clk);
            read_rx_byte = 1'b1;
            @(negedge clk);
            read_rx_byte = 1'b0;
            wait_ticks(16 - 1 - ST_VAL);
        end else begin
            wait_ticks(16);
        end
        $display("frame sent data=%02h bit8=%0d par=%0d odd=%0d pbit=%0d stop=%0d coincide=%0d",
                 data, b8, pen, odd, pbit, stop, coincide);
    endtask

    // Monitor: fires on a new byte, on overflow, or on a load that coincided with a read.
    initial begin
        bit   rd_seen;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            rd_seen = read_rx_byte;
            if (!reset && ((rx_ready && !prev_ready) || (overflow && !prev_ovf) ||
                           (rx_ready && prev_ready && rd_seen))) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_output actual=%02h required=none", rx_data);
                end else begin
                    e = exp_q.pop_front();
                    $display("rx byte=%02h pe=%0d fe=%0d ov=%0d (expect %02h %0d %0d %0d)",
                             rx_data, parity_err, framing_err, overflow, e.d, e.pe, e.fe, e.ov);
                    chk("rx_data", 32'(rx_data), 32'(e.d));
                    chk("parity_err", 32'(parity_err), 32'(e.pe));
                    chk("framing_err", 32'(framing_err), 32'(e.fe));
                    chk("overflow", 32'(overflow), 32'(e.ov));
                    if (auto_read) begin
                        read_rx_byte = 1'b1;
                        @(posedge clk);
                        #1;
                        read_rx_byte = 1'b0;
                        chk("read_clears_ready", 32'(rx_ready), 32'd0);
                        chk("read_clears_flags", 32'({parity_err, framing_err, overflow}), 32'd0);
                    end
                end
            end
            prev_ready = rx_ready;
            prev_ovf   = overflow;
        end
    end

    initial begin
        exp_t e;
        logic [7:0] d;
        bit b8, pen, odd, pb, st;

        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("reset_rx_data", 32'(rx_data), 32'd0);
        chk("reset_rx_ready", 32'(rx_ready), 32'd0);
        chk("reset_flags", 32'({parity_err, framing_err, overflow}), 32'd0);
        chk("reset_rx_idle", 32'(rx_idle), 32'd1);
        reset = 1'b0;
        wait_ticks(4);

        // 8N1 basic byte
        exp_q.push_back(model(8'hA5, 1, 0, 0, 0, 1));
        send_frame(8'hA5, 1, 0, 0, 0, 1, 0);
        wait_ticks(2);

        // False start: low for 4 ticks only
        wait_ticks(1);
        drive_bit(1'b0);
        wait_ticks(4);
        drive_bit(1'b1);
        wait_ticks(1);
        @(negedge clk);
        chk("false_start_busy", 32'(rx_idle), 32'd0);
        wait_ticks(6);
        @(negedge clk);
        chk("false_start_idle", 32'(rx_idle), 32'd1);
        $display("false start done idle=%0d", rx_idle);
`ifdef UART_RX_MAJORITY_VOTE_EN
        // One-tick start, then a lone low sample at count 8: majority says 1.
        wait_ticks(2);
        drive_bit(1'b0);
        wait_ticks(1);
        drive_bit(1'b1);
        wait_ticks(7);
        drive_bit(1'b0);
        wait_ticks(1);
        drive_bit(1'b1);
        wait_ticks(3);
        @(negedge clk);
        chk("glitch_rejected_idle", 32'(rx_idle), 32'd1);
        $display("glitch start done idle=%0d", rx_idle);
`endif
        wait_ticks(4);

        // Parity frames
        exp_q.push_back(model(8'h5A, 1, 1, 0, 0, 1));
        send_frame(8'h5A, 1, 1, 0, 0, 1, 0);
        exp_q.push_back(model(8'h5A, 1, 1, 0, 1, 1));
        send_frame(8'h5A, 1, 1, 0, 1, 1, 0);
        exp_q.push_back(model(8'h7F, 0, 1, 1, 0, 1));
        send_frame(8'h7F, 0, 1, 1, 0, 1, 0);

        // Break: stop bit low, line held low for 40 ticks
        exp_q.push_back(model(8'h33, 1, 0, 0, 0, 0));
        send_frame(8'h33, 1, 0, 0, 0, 0, 0);
        wait_ticks(20);
        @(negedge clk);
        chk("break_wait_high_a", 32'(rx_idle), 32'd0);
        wait_ticks(20);
        @(negedge clk);
        chk("break_wait_high_b", 32'(rx_idle), 32'd0);
        rx = 1'b1;
        wait_ticks(2);
        @(negedge clk);
        chk("break_released_idle", 32'(rx_idle), 32'd1);
        $display("break released idle=%0d", rx_idle);
        wait_ticks(4);

        // Overflow without reading
        auto_read = 1'b0;
        exp_q.push_back(model(8'h11, 1, 0, 0, 0, 1));
        send_frame(8'h11, 1, 0, 0, 0, 1, 0);
        e = model(8'h11, 1, 0, 0, 0, 1);
        e.ov = 1'b1;
        exp_q.push_back(e);
        send_frame(8'h22, 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
        chk("ovf_read_ready", 32'(rx_ready), 32'd0);
        chk("ovf_read_overflow", 32'(overflow), 32'd0);
        $display("overflow cleared ready=%0d ovf=%0d", rx_ready, overflow);

        // Read coincident with the second completion
        exp_q.push_back(model(8'h11, 1, 0, 0, 0, 1));
        send_frame(8'h11, 1, 0, 0, 0, 1, 0);
        exp_q.push_back(model(8'h22, 1, 0, 0, 0, 1));
        send_frame(8'h22, 1, 0, 0, 0, 1, 1);
        @(negedge clk);
        chk("coinc_ready", 32'(rx_ready), 32'd1);
        chk("coinc_data", 32'(rx_data), 32'h22);
        chk("coinc_overflow", 32'(overflow), 32'd0);
        $display("coincident read data=%02h ready=%0d ovf=%0d", rx_data, rx_ready, overflow);
        read_rx_byte = 1'b1;
        @(negedge clk);
        read_rx_byte = 1'b0;
        chk("coinc_read_ready", 32'(rx_ready), 32'd0);
        auto_read = 1'b1;
        wait_ticks(4);

        // Reset during data bit 3 of 0xFF, then a clean 0x81
        @(negedge clk);
        bit8 = 1'b1;
        parity_en = 1'b0;
        wait_ticks(1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            wait_ticks(16);
            drive_bit(1'b1);
        end
        wait_ticks(8);
        @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_idle", 32'(rx_idle), 32'd1);
        reset = 1'b0;
        wait_ticks(20);
        @(negedge clk);
        chk("midreset_no_frame", 32'({rx_ready, parity_err, framing_err, overflow}), 32'd0);
        $display("mid-frame reset done ready=%0d", rx_ready);
        exp_q.push_back(model(8'h81, 1, 0, 0, 0, 1));
        send_frame(8'h81, 1, 0, 0, 0, 1, 0);

        // Randomized frames
        for (int n = 0; n < 24; n++) begin
            d   = 8'($urandom);
            b8  = 1'($urandom_range(0, 1));
            pen = 1'($urandom_range(0, 1));
            odd = 1'($urandom_range(0, 1));
            pb  = 1'($urandom_range(0, 1));
            st  = ($urandom_range(0, 7) != 0);
            exp_q.push_back(model(d, b8, pen, odd, pb, st));
            send_frame(d, b8, pen, odd, pb, st, 0);
            if (!st) begin
                wait_ticks(4);
                @(negedge clk);
                rx = 1'b1;
            end
            wait_ticks($urandom_range(1, 5));
        end

        wait_ticks(8);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
